// File: rtl/alu_pkg.sv
// Shared definitions for the ALU write-back register file: default sizes,
// ALU opcode constants and the write-back FSM state encoding.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_N  = 16;
  localparam int ADDR_W = $clog2(REG_N);

  // ALU opcodes. MUL and SH produce a double-width result (o_high valid).
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_MUL  = 4'h8;
  localparam logic [3:0] OP_SH   = 4'h9;
  localparam logic [3:0] OP_SLT  = 4'hA;
  localparam logic [3:0] OP_SLTU = 4'hB;

  // Write-back FSM: IDLE accepts results, WR_HI drains the latched high half.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WR_HI = 1'b1
  } wb_state_e;

  // True for opcodes whose result carries a high half to write back.
  function automatic logic op_writes_high(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_SH);
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file with two combinational read ports and one synchronous write
// port. Reads see the stored contents only (no write-to-read bypass).
module regfile_2r1w #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 16,
  parameter int ADDR_W = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] mem_q [REG_N];

  generate
    for (genvar gi = 0; gi < REG_N; gi++) begin : g_reg
      logic [DATA_W-1:0] q_reg;

      // Each register loads when the write port addresses it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else if (we && (waddr == ADDR_W'(gi))) begin
          q_reg <= wdata;
        end
      end

      assign mem_q[gi] = q_reg;
    end
  endgenerate

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/alu_wb_regfile.sv
// ALU write-back register file. Accepts ALU results (low half, optional high
// half) and writes them through a single write port; a double-half result
// takes two cycles, the high half going to (rd+1) mod REG_N.
// Optional build macro: ALU_WB_ZERO_REG_EN makes register 0 hard-wired zero.
module alu_wb_regfile #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int REG_N  = alu_pkg::REG_N,
  parameter int ADDR_W = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_low,
  input  logic [DATA_W-1:0] in_high,
  input  logic              in_write_high,
  input  logic [ADDR_W-1:0] rs0_addr,
  input  logic [ADDR_W-1:0] rs1_addr,
  output logic [DATA_W-1:0] rs0_data,
  output logic [DATA_W-1:0] rs1_data,
  output logic              busy,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  import alu_pkg::*;

  wb_state_e         state_reg, state_next;
  logic [ADDR_W-1:0] hi_addr_reg;
  logic [DATA_W-1:0] hi_data_reg;
  logic              transfer;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rf_we;
  logic [DATA_W-1:0] trace_data;
  logic [DATA_W-1:0] rf_rdata0, rf_rdata1;
  logic              wb_valid_reg;
  logic [ADDR_W-1:0] wb_addr_reg;
  logic [DATA_W-1:0] wb_data_reg;

  assign in_ready = (state_reg == ST_IDLE);
  assign busy     = (state_reg == ST_WR_HI);
  assign transfer = in_valid && in_ready;

  // Next state and write-port selection: incoming low half in IDLE,
  // latched high half in WR_HI.
  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    wr_addr    = in_rd;
    wr_data    = in_low;
    case (state_reg)
      ST_IDLE: begin
        if (transfer) begin
          wr_en = 1'b1;
          if (in_write_high) begin
            state_next = ST_WR_HI;
          end
        end
      end
      ST_WR_HI: begin
        wr_en      = 1'b1;
        wr_addr    = hi_addr_reg;
        wr_data    = hi_data_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef ALU_WB_ZERO_REG_EN
  // Register 0 is never written; reads and the trace report it as zero.
  logic wr_zero;
  assign wr_zero    = (wr_addr == '0);
  assign rf_we      = wr_en && !wr_zero;
  assign trace_data = wr_zero ? '0 : wr_data;
  assign rs0_data   = (rs0_addr == '0) ? '0 : rf_rdata0;
  assign rs1_data   = (rs1_addr == '0) ? '0 : rf_rdata1;
`else
  assign rf_we      = wr_en;
  assign trace_data = wr_data;
  assign rs0_data   = rf_rdata0;
  assign rs1_data   = rf_rdata1;
`endif

  // State register; reset in WR_HI drops the pending high write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Latch the high half and its wrapped destination on a double-half transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_addr_reg <= '0;
      hi_data_reg <= '0;
    end else if (transfer && in_write_high) begin
      hi_addr_reg <= in_rd + ADDR_W'(1);
      hi_data_reg <= in_high;
    end
  end

  // Write trace: one-cycle strobe with the address/data of each write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_reg <= 1'b0;
      wb_addr_reg  <= '0;
      wb_data_reg  <= '0;
    end else begin
      wb_valid_reg <= wr_en;
      if (wr_en) begin
        wb_addr_reg <= wr_addr;
        wb_data_reg <= trace_data;
      end
    end
  end

  assign wb_valid = wb_valid_reg;
  assign wb_addr  = wb_addr_reg;
  assign wb_data  = wb_data_reg;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .waddr  (wr_addr),
    .wdata  (wr_data),
    .raddr0 (rs0_addr),
    .raddr1 (rs1_addr),
    .rdata0 (rf_rdata0),
    .rdata1 (rf_rdata1)
  );

endmodule

// File: tb/tb_alu_wb_regfile.sv
// Testbench for alu_wb_regfile: directed vector table, reset-during-WR_HI
// sequence and randomized traffic against a write-queue reference model.
// Honours ALU_WB_ZERO_REG_EN the same way as the design build.
module tb_alu_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rd;
  logic [15:0] in_low;
  logic [15:0] in_high;
  logic        in_write_high;
  logic [3:0]  rs0_addr, rs1_addr;
  logic [15:0] rs0_data, rs1_data;
  logic        busy;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_wb_regfile dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_low        (in_low),
    .in_high       (in_high),
    .in_write_high (in_write_high),
    .rs0_addr      (rs0_addr),
    .rs1_addr      (rs1_addr),
    .rs0_data      (rs0_data),
    .rs1_data      (rs1_data),
    .busy          (busy),
    .wb_valid      (wb_valid),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data)
  );

`ifdef ALU_WB_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  // Reference model: register contents plus a queue of writes still owed.
  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic [15:0] m_mem [16];
  wr_t         m_pend [$];
  logic        m_wbv;
  logic [3:0]  m_wba;
  logic [15:0] m_wbd;

  function automatic logic [15:0] m_read(input logic [3:0] a);
    if (ZERO_REG && a == 4'd0) return 16'h0000;
    return m_mem[a];
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
    m_pend.delete();
    m_wbv = 1'b0;
    m_wba = 4'd0;
    m_wbd = 16'h0000;
  endfunction

  function automatic void m_write(input logic [3:0] a, input logic [15:0] d);
    m_wbv = 1'b1;
    m_wba = a;
    if (ZERO_REG && a == 4'd0) begin
      m_wbd = 16'h0000;
    end else begin
      m_mem[a] = d;
      m_wbd    = d;
    end
  endfunction

  // One clock edge: drain an owed high write first, otherwise accept a result.
  function automatic void m_edge(input logic v, input logic [3:0] rd,
                                 input logic [15:0] lo, input logic [15:0] hi,
                                 input logic wh);
    wr_t w;
    m_wbv = 1'b0;
    if (m_pend.size() != 0) begin
      w = m_pend.pop_front();
      m_write(w.addr, w.data);
    end else if (v) begin
      m_write(rd, lo);
      if (wh) begin
        w.addr = 4'((int'(rd) + 1) % 16);
        w.data = hi;
        m_pend.push_back(w);
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Values observed around one clock edge.
  logic        pre_rdy, pre_busy;
  logic [15:0] pre_rs0, pre_rs1;
  logic        post_wbv, post_busy;
  logic [3:0]  post_wba;
  logic [15:0] post_wbd;

  // Called shortly after a rising edge with inputs already driven.
  task automatic run_cycle();
    #1;
    pre_rdy  = in_ready;
    pre_busy = busy;
    pre_rs0  = rs0_data;
    pre_rs1  = rs1_data;
    @(posedge clk);
    m_edge(in_valid, in_rd, in_low, in_high, in_write_high);
    #1;
    post_wbv  = wb_valid;
    post_wba  = wb_addr;
    post_wbd  = wb_data;
    post_busy = busy;
    $display("cycle v=%0b rd=%0d lo=%h hi=%h wh=%0b | rdy=%0b busy=%0b wb=%0b/%0d/%h",
             in_valid, in_rd, in_low, in_high, in_write_high,
             pre_rdy, pre_busy, post_wbv, post_wba, post_wbd);
  endtask

  typedef struct {
    logic        v;
    logic [3:0]  rd;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        wh;
    logic [3:0]  rs0;
    logic        e_rdy;
    logic        e_busy;
    logic [15:0] e_rs0;
    logic        e_wbv;
    logic [3:0]  e_wba;
    logic [15:0] e_wbd;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [15:0] r0_hi;
    r0_hi = ZERO_REG ? 16'h0000 : 16'hA5A5;

    // Directed sequence; pre-edge expectations first, trace after the edge.
    vecs[0] = '{1'b1, 4'd3,  16'h1234, 16'h0000, 1'b0, 4'd3,  1'b1, 1'b0, 16'h0000, 1'b1, 4'd3,  16'h1234};
    vecs[1] = '{1'b1, 4'd5,  16'hBEEF, 16'h0001, 1'b1, 4'd3,  1'b1, 1'b0, 16'h1234, 1'b1, 4'd5,  16'hBEEF};
    vecs[2] = '{1'b1, 4'd7,  16'h7777, 16'h0000, 1'b0, 4'd5,  1'b0, 1'b1, 16'hBEEF, 1'b1, 4'd6,  16'h0001};
    vecs[3] = '{1'b1, 4'd7,  16'h7777, 16'h0000, 1'b0, 4'd6,  1'b1, 1'b0, 16'h0001, 1'b1, 4'd7,  16'h7777};
    vecs[4] = '{1'b1, 4'd15, 16'hF00F, 16'hA5A5, 1'b1, 4'd7,  1'b1, 1'b0, 16'h7777, 1'b1, 4'd15, 16'hF00F};
    vecs[5] = '{1'b0, 4'd15, 16'hF00F, 16'hA5A5, 1'b1, 4'd15, 1'b0, 1'b1, 16'hF00F, 1'b1, 4'd0,  r0_hi};
    vecs[6] = '{1'b0, 4'd0,  16'h0000, 16'h0000, 1'b0, 4'd0,  1'b1, 1'b0, r0_hi,    1'b0, 4'd0,  16'h0000};

    rst_n = 1'b0;
    in_valid = 1'b0; in_rd = 4'd0; in_low = 16'h0; in_high = 16'h0; in_write_high = 1'b0;
    rs0_addr = 4'd0; rs1_addr = 4'd0;
    m_reset();

    // Reset state.
    #2;
    chk("rst_ready_async", 32'(in_ready), 32'd1);
    chk("rst_busy_async",  32'(busy),     32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      rs0_addr = 4'(i);
      rs1_addr = 4'(15 - i);
      #1;
      chk($sformatf("rst_rs0_r%0d", i), 32'(rs0_data), 32'd0);
      chk($sformatf("rst_rs1_r%0d", 15 - i), 32'(rs1_data), 32'd0);
    end
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_wbv",   32'(wb_valid), 32'd0);

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      in_valid = vecs[i].v; in_rd = vecs[i].rd; in_low = vecs[i].lo;
      in_high = vecs[i].hi; in_write_high = vecs[i].wh; rs0_addr = vecs[i].rs0;
      rs1_addr = 4'd3;
      run_cycle();
      chk($sformatf("vec%0d_ready", i), 32'(pre_rdy),  32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_busy",  i), 32'(pre_busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_rs0",   i), 32'(pre_rs0),  32'(vecs[i].e_rs0));
      chk($sformatf("vec%0d_wbv",   i), 32'(post_wbv), 32'(vecs[i].e_wbv));
      if (vecs[i].e_wbv) begin
        chk($sformatf("vec%0d_wba", i), 32'(post_wba), 32'(vecs[i].e_wba));
        chk($sformatf("vec%0d_wbd", i), 32'(post_wbd), 32'(vecs[i].e_wbd));
      end
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      in_valid      = ($urandom_range(3) != 0);
      in_rd         = 4'($urandom_range(15));
      in_low        = 16'($urandom);
      in_high       = 16'($urandom);
      in_write_high = ($urandom_range(2) == 0);
      rs0_addr      = 4'($urandom_range(15));
      rs1_addr      = 4'($urandom_range(15));
      #1;
      chk("rnd_ready", 32'(in_ready), 32'(m_pend.size() == 0));
      chk("rnd_busy",  32'(busy),     32'(m_pend.size() != 0));
      chk("rnd_rs0",   32'(rs0_data), 32'(m_read(rs0_addr)));
      chk("rnd_rs1",   32'(rs1_data), 32'(m_read(rs1_addr)));
      run_cycle();
      chk("rnd_wbv", 32'(post_wbv), 32'(m_wbv));
      if (m_wbv) begin
        chk("rnd_wba", 32'(post_wba), 32'(m_wba));
        chk("rnd_wbd", 32'(post_wbd), 32'(m_wbd));
      end
    end

    // Reset during WR_HI: the owed high write must never happen.
    in_valid = 1'b0;
    run_cycle();
    in_valid = 1'b1; in_rd = 4'd9; in_low = 16'h1111; in_high = 16'h2222;
    in_write_high = 1'b1; rs0_addr = 4'd9; rs1_addr = 4'd10;
    run_cycle();
    chk("rwh_busy_before", 32'(post_busy), 32'd1);
    chk("rwh_reg9_written", 32'(rs0_data), 32'h1111);
    in_valid = 1'b0;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rwh_ready", 32'(in_ready), 32'd1);
    chk("rwh_busy",  32'(busy),     32'd0);
    chk("rwh_wbv",   32'(wb_valid), 32'd0);
    chk("rwh_reg9",  32'(rs0_data), 32'd0);
    chk("rwh_reg10", 32'(rs1_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rwh_reg10_after", 32'(rs1_data), 32'd0);
    chk("rwh_wbv_after",   32'(wb_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
